// File: rtl/serializer_pkg.sv
// Shared types and sizing helpers for the serializer/deserializer pair.
package serializer_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int unsigned DESERIALIZER_WD_DEFAULT = 8;

    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w);
    endfunction

endpackage

// File: rtl/serializer.sv
// Parallel-to-serial converter, LSB first, with a one-word holding register
// so that back-to-back words leave as a gapless bit stream.
module serializer
    import serializer_pkg::*;
#(
    parameter int unsigned DESERIALIZER_WD = DESERIALIZER_WD_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       valid_in,
    input  logic [DESERIALIZER_WD-1:0] data_in,
    output logic                       ready_out,
    output logic                       data_out,
    output logic                       valid_out,
    output logic                       last_out
);

    localparam int unsigned CW = cnt_width(DESERIALIZER_WD);
    localparam logic [CW-1:0] CNT_LAST = CW'(DESERIALIZER_WD - 1);

    state_t                     state, state_d;
    logic [DESERIALIZER_WD-1:0] shreg, shreg_d;
    logic [DESERIALIZER_WD-1:0] hold, hold_d;
    logic                       hold_vld, hold_vld_d;
    logic [CW-1:0]              cnt, cnt_d;
    logic                       accept;

    assign ready_out = rst && !hold_vld;
    assign accept    = valid_in && ready_out;

    assign data_out  = shreg[0];
    assign valid_out = (state == SHIFT);
    assign last_out  = (state == SHIFT) && (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            shreg    <= '0;
            hold     <= '0;
            hold_vld <= 1'b0;
            cnt      <= '0;
        end else begin
            state    <= state_d;
            shreg    <= shreg_d;
            hold     <= hold_d;
            hold_vld <= hold_vld_d;
            cnt      <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state;
        shreg_d    = shreg;
        hold_d     = hold;
        hold_vld_d = hold_vld;
        cnt_d      = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    shreg_d = data_in;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt != CNT_LAST) begin
                    shreg_d = shreg >> 1;
                    cnt_d   = cnt + CW'(1);
                    if (accept) begin
                        hold_d     = data_in;
                        hold_vld_d = 1'b1;
                    end
                end else if (hold_vld) begin
                    // ready_out is low here, so a pending upstream word waits one cycle
                    shreg_d    = hold;
                    cnt_d      = '0;
                    hold_vld_d = 1'b0;
                end else if (accept) begin
                    shreg_d = data_in;
                    cnt_d   = '0;
                end else begin
                    shreg_d = '0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_serializer.sv
// Self-checking bench for serializer; reference is a bit-level FIFO of pending output bits.
module tb_serializer;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         valid_in;
    logic [W-1:0] data_in;
    logic         ready_out, data_out, valid_out, last_out;

    logic         rst2, valid2, ready2, dout2, vout2, lout2;
    logic [1:0]   data2;

    int vectors     = 0;
    int miscompares = 0;

    bit q_data[$];
    bit q_last[$];
    bit acc;

    always #5 clk = ~clk;

    serializer #(.DESERIALIZER_WD(W)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .data_in(data_in),
        .ready_out(ready_out), .data_out(data_out), .valid_out(valid_out), .last_out(last_out)
    );

    serializer #(.DESERIALIZER_WD(2)) dut2 (
        .clk(clk), .rst(rst2), .valid_in(valid2), .data_in(data2),
        .ready_out(ready2), .data_out(dout2), .valid_out(vout2), .last_out(lout2)
    );

    // Model: the front of the queue is the bit on the wire; at most one word may wait beyond it.
    task automatic tick(input logic r, input logic v, input logic [W-1:0] d);
        rst = r; valid_in = v; data_in = d;
        @(posedge clk);
        acc = 1'b0;
        if (!r) begin
            q_data.delete();
            q_last.delete();
        end else begin
            acc = v && (q_data.size() <= W);
            if (q_data.size() != 0) begin
                void'(q_data.pop_front());
                void'(q_last.pop_front());
            end
            if (acc) begin
                for (int i = 0; i < int'(W); i++) begin
                    q_data.push_back(d[i]);
                    q_last.push_back(i == int'(W) - 1);
                end
            end
        end
        #1;
    endtask

    function automatic logic [3:0] exp_vec();
        logic nz;
        nz = (q_data.size() != 0);
        return {rst && (q_data.size() <= W), nz, nz ? logic'(q_data[0]) : 1'b0, nz ? logic'(q_last[0]) : 1'b0};
    endfunction

    function automatic logic [3:0] obs_vec();
        return {ready_out, valid_out, data_out, last_out};
    endfunction

    task automatic test_reset();
        tick(1'b0, 1'b0, '0);
        tick(1'b0, 1'b1, 8'hFF);
        vectors++;
        if (obs_vec() !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_state: rdy/vld/dat/last got %b expected 0000", obs_vec());
        end
        rst = 1'b1; valid_in = 1'b0; data_in = '0;
        #1;
        vectors++;
        if (obs_vec() !== 4'b1000) begin
            miscompares++;
            $display("FAIL reset_release: rdy/vld/dat/last got %b expected 1000", obs_vec());
        end
    endtask

    task automatic test_single_word();
        logic [W-1:0] bits = '0;
        int n = 0, nlast = 0, lastpos = -1;
        tick(1'b1, 1'b1, 8'hA5);
        for (int i = 0; i < 10; i++) begin
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL single_word cycle %0d: got %b expected %b", i, obs_vec(), exp_vec());
            end
            if (valid_out) begin
                if (n < int'(W)) bits[n] = data_out;
                if (last_out) begin nlast++; lastpos = n; end
                n++;
            end
            tick(1'b1, 1'b0, '0);
        end
        vectors++;
        if (bits !== 8'hA5 || n != 8 || nlast != 1 || lastpos != 7) begin
            miscompares++;
            $display("FAIL single_word_stream: got word %h bits %0d lasts %0d at %0d expected a5 8 1 7",
                     bits, n, nlast, lastpos);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] words [3] = '{8'h01, 8'hFF, 8'h80};
        logic [23:0] s = '0;
        int idx = 0, n = 0;
        bit started = 0, gap = 0;
        for (int c = 0; c < 40; c++) begin
            if (idx < 3) tick(1'b1, 1'b1, words[idx]);
            else         tick(1'b1, 1'b0, '0);
            if (acc) idx++;
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL back_to_back cycle %0d: got %b expected %b", c, obs_vec(), exp_vec());
            end
            if (valid_out) begin
                if (n < 24) s[n] = data_out;
                n++;
                started = 1;
            end else if (started && n < 24) gap = 1;
        end
        vectors++;
        if (s !== 24'h80FF01 || n != 24 || gap || idx != 3) begin
            miscompares++;
            $display("FAIL back_to_back_stream: got %h bits %0d gap %0d words %0d expected 80ff01 24 0 3",
                     s, n, gap, idx);
        end
    endtask

    task automatic test_late_offer();
        logic [15:0] s = '0;
        int n = 0;
        bit started = 0, gap = 0;
        tick(1'b1, 1'b1, 8'hC3);
        for (int c = 0; c < 24; c++) begin
            if (c == 5) begin
                tick(1'b1, 1'b1, 8'h3C);
                vectors++;
                if (ready_out !== 1'b0 || !acc) begin
                    miscompares++;
                    $display("FAIL late_offer_ready: ready_out %b accepted %0d expected 0 1", ready_out, acc);
                end
            end
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL late_offer cycle %0d: got %b expected %b", c, obs_vec(), exp_vec());
            end
            if (valid_out) begin
                if (n < 16) s[n] = data_out;
                n++;
                started = 1;
            end else if (started && n < 16) gap = 1;
            if (c != 4) tick(1'b1, 1'b0, '0);
        end
        vectors++;
        if (s !== 16'h3CC3 || n != 16 || gap) begin
            miscompares++;
            $display("FAIL late_offer_stream: got %h bits %0d gap %0d expected 3cc3 16 0", s, n, gap);
        end
    endtask

    task automatic test_reset_mid_word();
        logic [W-1:0] bits = '0;
        int n = 0;
        tick(1'b1, 1'b1, 8'h5A);
        tick(1'b1, 1'b1, 8'hE7);
        tick(1'b1, 1'b0, '0);
        tick(1'b1, 1'b0, '0);
        tick(1'b0, 1'b0, '0);
        vectors++;
        if (obs_vec() !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_mid_word: got %b expected 0000", obs_vec());
        end
        rst = 1'b1;
        #1;
        vectors++;
        if (ready_out !== 1'b1 || valid_out !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_release: ready %b valid %b expected 1 0", ready_out, valid_out);
        end
        tick(1'b1, 1'b1, 8'h0F);
        for (int c = 0; c < 12; c++) begin
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL reset_mid_word cycle %0d: got %b expected %b", c, obs_vec(), exp_vec());
            end
            if (valid_out) begin
                if (n < int'(W)) bits[n] = data_out;
                n++;
            end
            tick(1'b1, 1'b0, '0);
        end
        vectors++;
        if (bits !== 8'h0F || n != 8) begin
            miscompares++;
            $display("FAIL reset_mid_stream: got %h bits %0d expected 0f 8", bits, n);
        end
    endtask

    task automatic test_width2();
        logic [1:0] w2 [3] = '{2'b01, 2'b10, 2'b11};
        logic [5:0] s = '0, l = '0;
        int idx = 0, n = 0;
        bit started = 0, gap = 0, a;
        rst2 = 1'b0; valid2 = 1'b0; data2 = '0;
        @(posedge clk); @(posedge clk); #1;
        rst2 = 1'b1;
        for (int c = 0; c < 20; c++) begin
            valid2 = (idx < 3);
            data2  = '0;
            if (idx < 3) data2 = w2[idx];
            #1;
            a = valid2 && ready2;
            @(posedge clk); #1;
            if (a) idx++;
            if (vout2) begin
                if (n < 6) begin s[n] = dout2; l[n] = lout2; end
                n++;
                started = 1;
            end else if (started && n < 6) gap = 1;
        end
        valid2 = 1'b0;
        vectors++;
        if (s !== 6'b111001 || l !== 6'b101010 || n != 6 || gap) begin
            miscompares++;
            $display("FAIL width2_stream: bits %b lasts %b count %0d gap %0d expected 111001 101010 6 0",
                     s, l, n, gap);
        end
    endtask

    task automatic test_loopback_random();
        logic [W-1:0] expq[$];
        logic [W-1:0] word = '0, rxw = '0, e;
        int sent = 0, recvd = 0, gap = 0, bi = 0;
        bit have = 0;
        for (int c = 0; c < 3000 && recvd < 200; c++) begin
            if (!have && sent < 200) begin
                if (gap == 0) begin
                    word = W'($urandom);
                    have = 1;
                    gap  = $urandom_range(0, 3);
                end else gap--;
            end
            tick(1'b1, have, have ? word : '0);
            if (acc) begin
                expq.push_back(word);
                have = 0;
                sent++;
            end
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL loopback cycle %0d: got %b expected %b", c, obs_vec(), exp_vec());
            end
            if (valid_out) begin
                if (bi < int'(W)) rxw[bi] = data_out;
                bi++;
                if (last_out) begin
                    e = expq.size() != 0 ? expq.pop_front() : 'x;
                    vectors++;
                    if (rxw !== e || bi != int'(W)) begin
                        miscompares++;
                        $display("FAIL loopback_word %0d: got %h in %0d bits expected %h in 8", recvd, rxw, bi, e);
                    end
                    recvd++;
                    bi = 0;
                end
            end
        end
        vectors++;
        if (recvd != 200 || sent != 200) begin
            miscompares++;
            $display("FAIL loopback_count: received %0d sent %0d expected 200 200", recvd, sent);
        end
    endtask

    initial begin
        rst = 1'b0; valid_in = 1'b0; data_in = '0;
        rst2 = 1'b0; valid2 = 1'b0; data2 = '0;
        test_reset();
        test_single_word();
        test_back_to_back();
        test_late_offer();
        test_reset_mid_word();
        test_width2();
        test_loopback_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
